// File: rtl/slice_writer_if.sv
// Pixel stream in, framebuffer-bank write port out.
interface slice_writer_if;
   logic        rgb_valid;
   logic [23:0] rgb_data;
   logic        rgb_sof;
   logic [3:0]  block_number;
   logic [6:0]  pixel_number;
   logic [23:0] ram_data;
   logic        block_write_enable;
   logic [7:0]  wslice_cnt;
   logic        SOF;
   logic        EOS;
   logic        frame_error;

   modport slave (
      input  rgb_valid,
      input  rgb_data,
      input  rgb_sof,
      output block_number,
      output pixel_number,
      output ram_data,
      output block_write_enable,
      output wslice_cnt,
      output SOF,
      output EOS,
      output frame_error
   );

   modport master (
      output rgb_valid,
      output rgb_data,
      output rgb_sof,
      input  block_number,
      input  pixel_number,
      input  ram_data,
      input  block_write_enable,
      input  wslice_cnt,
      input  SOF,
      input  EOS,
      input  frame_error
   );
endinterface

// File: rtl/slice_writer.sv
// Slices a framed RGB stream into per-slice, per-block RAM writes
// and flags malformed frames.
module slice_writer #(
   parameter int NB_BLOCKS        = 15,
   parameter int PIXELS_PER_BLOCK = 128,
   parameter int NB_SLICES        = 128
) (
   input logic           clk,
   input logic           nrst,
   slice_writer_if.slave bus
);
   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [6:0] PIX_LAST = 7'(PIXELS_PER_BLOCK - 1);
   localparam logic [3:0] BLK_LAST = 4'(NB_BLOCKS - 1);
   localparam logic [7:0] SLC_LAST = 8'(NB_SLICES - 1);

   state_t      state, state_nx;
   logic [6:0]  pix_cnt, pix_nx;
   logic [3:0]  blk_cnt, blk_nx;
   logic [7:0]  slc_cnt, slc_nx;

   logic        we_q, we_nx;
   logic        sof_q, sof_nx;
   logic        eos_q, eos_nx;
   logic        err_q, err_nx;
   logic [3:0]  bn_q, bn_nx;
   logic [6:0]  pn_q, pn_nx;
   logic [23:0] dat_q, dat_nx;
   logic [7:0]  ws_q, ws_nx;

   logic        wr;
   logic        restart;
   logic        eos_hit;
   logic        frame_end;
   logic [6:0]  wp;
   logic [3:0]  wb;
   logic [7:0]  ws;

   always_comb begin
      state_nx  = state;
      pix_nx    = pix_cnt;
      blk_nx    = blk_cnt;
      slc_nx    = slc_cnt;
      err_nx    = 1'b0;
      wr        = 1'b0;
      restart   = bus.rgb_valid & bus.rgb_sof;

      unique case (state)
         IDLE: begin
            if (bus.rgb_valid) begin
               wr     = bus.rgb_sof;
               err_nx = ~bus.rgb_sof;
            end
         end
         STREAM: begin
            if (bus.rgb_valid) begin
               wr     = 1'b1;
               err_nx = bus.rgb_sof;
            end
         end
         default: ;
      endcase

      // A start-of-frame always rewinds to the origin, whatever the counters say.
      wp        = restart ? 7'd0 : pix_cnt;
      wb        = restart ? 4'd0 : blk_cnt;
      ws        = restart ? 8'd0 : slc_cnt;
      eos_hit   = (wp == PIX_LAST) && (wb == BLK_LAST);
      frame_end = eos_hit && (ws == SLC_LAST);

      if (wr) begin
         state_nx = STREAM;
         if (eos_hit) begin
            pix_nx = 7'd0;
            blk_nx = 4'd0;
            if (frame_end) begin
               slc_nx   = 8'd0;
               state_nx = IDLE;
            end else begin
               slc_nx = ws + 8'd1;
            end
         end else if (wp == PIX_LAST) begin
            pix_nx = 7'd0;
            blk_nx = wb + 4'd1;
            slc_nx = ws;
         end else begin
            pix_nx = wp + 7'd1;
            blk_nx = wb;
            slc_nx = ws;
         end
      end

      we_nx  = wr;
      sof_nx = wr & restart;
      eos_nx = wr & eos_hit;
      bn_nx  = wr ? wb : bn_q;
      pn_nx  = wr ? wp : pn_q;
      ws_nx  = wr ? ws : ws_q;
      dat_nx = wr ? bus.rgb_data : dat_q;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= IDLE;
         pix_cnt <= '0;
         blk_cnt <= '0;
         slc_cnt <= '0;
      end else begin
         state   <= state_nx;
         pix_cnt <= pix_nx;
         blk_cnt <= blk_nx;
         slc_cnt <= slc_nx;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         we_q  <= 1'b0;
         sof_q <= 1'b0;
         eos_q <= 1'b0;
         err_q <= 1'b0;
         bn_q  <= '0;
         pn_q  <= '0;
         dat_q <= '0;
         ws_q  <= '0;
      end else begin
         we_q  <= we_nx;
         sof_q <= sof_nx;
         eos_q <= eos_nx;
         err_q <= err_nx;
         bn_q  <= bn_nx;
         pn_q  <= pn_nx;
         dat_q <= dat_nx;
         ws_q  <= ws_nx;
      end
   end

   assign bus.block_write_enable = we_q;
   assign bus.SOF                = sof_q;
   assign bus.EOS                = eos_q;
   assign bus.frame_error        = err_q;
   assign bus.block_number       = bn_q;
   assign bus.pixel_number       = pn_q;
   assign bus.ram_data           = dat_q;
   assign bus.wslice_cnt         = ws_q;
endmodule
